// File: rtl/sfft_stream_decoder_pkg.sv
// Shared types and helpers for the stochastic FFT stream back-end.
// Used by the decoder and by the binary-to-stream encoders.
package sfft_stream_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        ACCUM  = 2'd2
    } state_t;

    localparam int DEF_BITWIDTH  = 8;
    localparam int DEF_NUMINPUTS = 8;
    localparam int DEF_LATENCY   = 3;

    function automatic int window_of(input int bw);
        return 1 << bw;
    endfunction

    // Bipolar range [-WINDOW, +WINDOW] needs two bits beyond BITWIDTH.
    function automatic int ow_of(input int bw);
        return bw + 2;
    endfunction

endpackage

// File: rtl/sfft_stream_decoder_ubit_counter.sv
// Per-lane unary bit counter with bipolar conversion of the final count.
// The value output already includes the bit presented this cycle.
module ubit_counter
    import sfft_stream_decoder_pkg::*;
#(
    parameter int BITWIDTH = DEF_BITWIDTH,
    parameter int OW       = ow_of(BITWIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 sample,
    output logic signed [OW-1:0] value
);

    localparam int CW = BITWIDTH + 1;
    localparam logic [OW-1:0] WIN = OW'(window_of(BITWIDTH));

    logic [CW-1:0] count;
    logic [CW-1:0] total;
    logic [OW-1:0] dbl;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(sample);
        end
    end

    assign total = count + CW'(sample);
    assign dbl   = OW'({total, 1'b0});
    assign value = dbl - WIN;

endmodule

// File: rtl/sfft_stream_decoder.sv
// Integrates NUMINPUTS real and imaginary unary streams over 2^BITWIDTH
// enabled samples and emits one signed bipolar value per lane.
module sfft_stream_decoder
    import sfft_stream_decoder_pkg::*;
#(
    parameter int BITWIDTH  = DEF_BITWIDTH,
    parameter int NUMINPUTS = DEF_NUMINPUTS,
    parameter int LATENCY   = DEF_LATENCY,
    parameter int OW        = ow_of(BITWIDTH)
) (
    input  logic                    iClk,
    input  logic                    iRst,
    input  logic                    iEn,
    input  logic                    iClr,
    input  logic                    iStart,
    input  logic [NUMINPUTS-1:0]    iReal,
    input  logic [NUMINPUTS-1:0]    iImg,
    output logic                    oBusy,
    output logic                    oValid,
    output logic [NUMINPUTS*OW-1:0] oReal,
    output logic [NUMINPUTS*OW-1:0] oImg
);

    localparam int WINDOW = window_of(BITWIDTH);
    localparam int PMAX   = (LATENCY > WINDOW) ? LATENCY : WINDOW;
    localparam int PW     = $clog2(PMAX + 1);
    localparam logic [PW-1:0] LAST_WARM =
        PW'((LATENCY > 0) ? LATENCY - 1 : 0);
    localparam logic [PW-1:0] LAST_SAMPLE = PW'(WINDOW - 1);

    state_t        state;
    state_t        state_n;
    logic [PW-1:0] phase;
    logic [PW-1:0] phase_n;
    logic          accept;
    logic          step;
    logic          done;
    logic          lane_clr;

    logic [NUMINPUTS*OW-1:0] real_val;
    logic [NUMINPUTS*OW-1:0] img_val;
    logic [NUMINPUTS*OW-1:0] real_q;
    logic [NUMINPUTS*OW-1:0] img_q;
    logic                    valid_q;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= IDLE;
            phase <= '0;
        end else begin
            state <= state_n;
            phase <= phase_n;
        end
    end

    always_comb begin
        state_n = state;
        phase_n = phase;
        accept  = 1'b0;
        step    = 1'b0;
        done    = 1'b0;
        if (iClr) begin
            state_n = IDLE;
            phase_n = '0;
        end else if (iEn) begin
            unique case (state)
                IDLE: begin
                    if (iStart) begin
                        accept  = 1'b1;
                        phase_n = '0;
                        state_n = (LATENCY > 0) ? WARMUP : ACCUM;
                    end
                end
                WARMUP: begin
                    if (phase == LAST_WARM) begin
                        phase_n = '0;
                        state_n = ACCUM;
                    end else begin
                        phase_n = phase + PW'(1);
                    end
                end
                ACCUM: begin
                    step = 1'b1;
                    if (phase == LAST_SAMPLE) begin
                        done    = 1'b1;
                        phase_n = '0;
                        state_n = IDLE;
                    end else begin
                        phase_n = phase + PW'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    phase_n = '0;
                end
            endcase
        end
    end

    // Abort and a fresh start both discard any partial lane counts.
    assign lane_clr = iClr | accept;

    for (genvar k = 0; k < NUMINPUTS; k++) begin : g_lane
        ubit_counter #(
            .BITWIDTH(BITWIDTH),
            .OW      (OW)
        ) u_re (
            .clk   (iClk),
            .rst   (iRst),
            .clr   (lane_clr),
            .en    (step),
            .sample(iReal[k]),
            .value (real_val[k*OW +: OW])
        );
        ubit_counter #(
            .BITWIDTH(BITWIDTH),
            .OW      (OW)
        ) u_im (
            .clk   (iClk),
            .rst   (iRst),
            .clr   (lane_clr),
            .en    (step),
            .sample(iImg[k]),
            .value (img_val[k*OW +: OW])
        );
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            valid_q <= 1'b0;
            real_q  <= '0;
            img_q   <= '0;
        end else begin
            valid_q <= done;
            if (done) begin
                real_q <= real_val;
                img_q  <= img_val;
            end
        end
    end

    assign oBusy  = (state != IDLE);
    assign oValid = valid_q;
    assign oReal  = real_q;
    assign oImg   = img_q;

endmodule

// File: tb/tb_sfft_stream_decoder.sv
// Randomized bench for sfft_stream_decoder with a window-level count model.
// Tasks run scenarios in sequence and compare against model expectations.
module tb_sfft_stream_decoder;

    localparam int BW  = 8;
    localparam int NI  = 8;
    localparam int LAT = 3;
    localparam int OW  = BW + 2;
    localparam int WIN = 1 << BW;

    logic             iClk = 1'b0;
    logic             iRst;
    logic             iEn;
    logic             iClr;
    logic             iStart;
    logic [NI-1:0]    iReal;
    logic [NI-1:0]    iImg;
    logic             oBusy;
    logic             oValid;
    logic [NI*OW-1:0] oReal;
    logic [NI*OW-1:0] oImg;

    logic [NI*OW-1:0] exp_r;
    logic [NI*OW-1:0] exp_i;
    int               passed;
    int               total;

    sfft_stream_decoder #(
        .BITWIDTH (BW),
        .NUMINPUTS(NI),
        .LATENCY  (LAT),
        .OW       (OW)
    ) dut (
        .iClk  (iClk),
        .iRst  (iRst),
        .iEn   (iEn),
        .iClr  (iClr),
        .iStart(iStart),
        .iReal (iReal),
        .iImg  (iImg),
        .oBusy (oBusy),
        .oValid(oValid),
        .oReal (oReal),
        .oImg  (oImg)
    );

    always #5 iClk = ~iClk;

    // Starts a window at the current negedge; ends at the oValid negedge.
    task automatic run_window(input int mode, input bit gate,
                              input bit poke, input string nm);
        int            en_cnt;
        int            cyc;
        int            s;
        int            ones_r[NI];
        int            ones_i[NI];
        bit            busy_bad;
        bit            valid_bad;
        logic [NI-1:0] r;
        logic [NI-1:0] m;
        for (int k = 0; k < NI; k++) begin
            ones_r[k] = 0;
            ones_i[k] = 0;
        end
        busy_bad  = 1'b0;
        valid_bad = 1'b0;
        en_cnt    = 0;
        cyc       = 0;
        iStart    = 1'b1;
        iEn       = 1'b1;
        iReal     = NI'($urandom);
        iImg      = NI'($urandom);
        while (en_cnt < LAT + WIN) begin
            @(negedge iClk);
            iStart = poke ? ($urandom_range(0, 7) == 0) : 1'b0;
            if (oBusy !== 1'b1) busy_bad = 1'b1;
            if (oValid !== 1'b0) valid_bad = 1'b1;
            iEn = gate ? (cyc % 2 == 1) : 1'b1;
            r = NI'($urandom);
            m = NI'($urandom);
            if (iEn) begin
                en_cnt++;
                if (en_cnt > LAT) begin
                    s = en_cnt - LAT - 1;
                    for (int k = 0; k < NI; k++) begin
                        case (mode)
                            0: begin r[k] = 1'b1; m[k] = 1'b1; end
                            1: begin r[k] = 1'b0; m[k] = 1'b0; end
                            2: begin
                                r[k] = (s < 32 * k);
                                m[k] = (s < 32 * (NI - 1 - k));
                            end
                            default: ;
                        endcase
                        ones_r[k] += int'(r[k]);
                        ones_i[k] += int'(m[k]);
                    end
                end
            end
            iReal = r;
            iImg  = m;
            cyc++;
        end
        @(negedge iClk);
        iStart = 1'b0;
        for (int k = 0; k < NI; k++) begin
            exp_r[k*OW +: OW] = OW'(2 * ones_r[k] - WIN);
            exp_i[k*OW +: OW] = OW'(2 * ones_i[k] - WIN);
        end
        total++;
        if (busy_bad || valid_bad)
            $display("FAIL %s_profile busy_bad=%0b valid_bad=%0b req=0/0",
                     nm, busy_bad, valid_bad);
        else passed++;
        total++;
        if (oValid !== 1'b1)
            $display("FAIL %s_valid got=%b req=1", nm, oValid);
        else passed++;
        total++;
        if (oBusy !== 1'b0)
            $display("FAIL %s_busy got=%b req=0", nm, oBusy);
        else passed++;
        total++;
        if (oReal !== exp_r)
            $display("FAIL %s_real got=%h req=%h", nm, oReal, exp_r);
        else passed++;
        total++;
        if (oImg !== exp_i)
            $display("FAIL %s_img got=%h req=%h", nm, oImg, exp_i);
        else passed++;
    endtask

    // Starts a window and stops after n samples have been driven.
    task automatic run_partial(input int n);
        int en_cnt;
        en_cnt = 0;
        iStart = 1'b1;
        iEn    = 1'b1;
        while (en_cnt < LAT + n) begin
            @(negedge iClk);
            iStart = 1'b0;
            iReal  = NI'($urandom);
            iImg   = NI'($urandom);
            en_cnt++;
        end
    endtask

    task automatic check_hold(input bit en, input string nm);
        iEn = en;
        @(negedge iClk);
        total++;
        if (oValid !== 1'b0)
            $display("FAIL %s_pulse got=%b req=0", nm, oValid);
        else passed++;
        total++;
        if (oReal !== exp_r || oImg !== exp_i)
            $display("FAIL %s_hold got=%h/%h req=%h/%h",
                     nm, oReal, oImg, exp_r, exp_i);
        else passed++;
        iEn = 1'b1;
    endtask

    task automatic watch_quiet(input int n, input string nm);
        bit bad;
        bad = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(negedge iClk);
            iReal = NI'($urandom);
            iImg  = NI'($urandom);
            if (oValid !== 1'b0 || oBusy !== 1'b0) bad = 1'b1;
        end
        total++;
        if (bad) $display("FAIL %s_quiet got=activity req=none", nm);
        else passed++;
    endtask

    task automatic test_reset();
        iRst   = 1'b1;
        iEn    = 1'b1;
        iClr   = 1'b0;
        iStart = 1'b1;
        iReal  = '1;
        iImg   = '1;
        repeat (3) @(negedge iClk);
        iRst   = 1'b0;
        iStart = 1'b0;
        exp_r  = '0;
        exp_i  = '0;
        total++;
        if (oBusy !== 1'b0) $display("FAIL rst_busy got=%b req=0", oBusy);
        else passed++;
        total++;
        if (oValid !== 1'b0) $display("FAIL rst_valid got=%b req=0", oValid);
        else passed++;
        total++;
        if (oReal !== '0) $display("FAIL rst_real got=%h req=0", oReal);
        else passed++;
        total++;
        if (oImg !== '0) $display("FAIL rst_img got=%h req=0", oImg);
        else passed++;
        @(negedge iClk);
    endtask

    task automatic test_constant();
        run_window(0, 1'b0, 1'b0, "ones");
        check_hold(1'b1, "ones");
        run_window(1, 1'b0, 1'b0, "zeros");
        check_hold(1'b1, "zeros");
    endtask

    task automatic test_ramp();
        run_window(2, 1'b0, 1'b0, "ramp");
        check_hold(1'b1, "ramp");
    endtask

    task automatic test_random();
        run_window(3, 1'b0, 1'b1, "rand_a");
        check_hold(1'b1, "rand_a");
        run_window(3, 1'b0, 1'b1, "rand_b");
        check_hold(1'b1, "rand_b");
    endtask

    task automatic test_gated_en();
        run_window(3, 1'b1, 1'b0, "gated");
        check_hold(1'b0, "gated");
    endtask

    task automatic test_clr();
        run_partial(100);
        @(negedge iClk);
        iClr   = 1'b1;
        iStart = 1'b1;
        @(negedge iClk);
        iClr   = 1'b0;
        iStart = 1'b0;
        total++;
        if (oBusy !== 1'b0 || oValid !== 1'b0)
            $display("FAIL clr_state got=%b%b req=00", oBusy, oValid);
        else passed++;
        total++;
        if (oReal !== exp_r || oImg !== exp_i)
            $display("FAIL clr_hold got=%h/%h req=%h/%h",
                     oReal, oImg, exp_r, exp_i);
        else passed++;
        watch_quiet(300, "clr");
        run_window(2, 1'b0, 1'b0, "after_clr");
        check_hold(1'b1, "after_clr");
    endtask

    task automatic test_rst_mid();
        run_partial(50);
        @(negedge iClk);
        iRst = 1'b1;
        @(negedge iClk);
        iRst  = 1'b0;
        exp_r = '0;
        exp_i = '0;
        total++;
        if (oBusy !== 1'b0 || oValid !== 1'b0)
            $display("FAIL rstmid_state got=%b%b req=00", oBusy, oValid);
        else passed++;
        total++;
        if (oReal !== '0 || oImg !== '0)
            $display("FAIL rstmid_out got=%h/%h req=0/0", oReal, oImg);
        else passed++;
        watch_quiet(300, "rstmid");
    endtask

    task automatic test_back_to_back();
        run_window(3, 1'b0, 1'b0, "b2b_a");
        run_window(0, 1'b0, 1'b0, "b2b_b");
        run_window(2, 1'b0, 1'b0, "b2b_c");
        check_hold(1'b1, "b2b_c");
    endtask

    initial begin
        passed = 0;
        total  = 0;
        exp_r  = '0;
        exp_i  = '0;
        test_reset();
        test_constant();
        test_ramp();
        test_random();
        test_gated_en();
        test_clr();
        test_rst_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
